// File: rtl/mouse_redraw_ctrl.sv
// mouse_redraw_ctrl: sequences a full-screen erase followed by a cursor draw on every
// mouse-move event.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   move                single-cycle pulse, mouse position changed
//   mouse_x, mouse_y    current cursor position (sampled when a redraw starts)
//   scan_x, scan_y      coordinates from the erase scanner
//   delete_signal       run request to the erase scanner (high for one full frame)
//   plot, draw_x/y      VGA write enable and pixel coordinates
//   colour_sel          0 = background RAM q, 1 = cursor colour
//   busy                high whenever a redraw is in progress
//   done                single-cycle pulse when a redraw completes
module mouse_redraw_ctrl #(
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120,
  parameter int unsigned CUR_W = 4,
  parameter int unsigned CUR_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move,
  input  logic [7:0] mouse_x,
  input  logic [6:0] mouse_y,
  input  logic [7:0] scan_x,
  input  logic [6:0] scan_y,
  output logic       delete_signal,
  output logic       plot,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       colour_sel,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] XLast   = 8'(SCR_W - 1);
  localparam logic [6:0] YLast   = 7'(SCR_H - 1);
  localparam logic [8:0] XLimit  = 9'(SCR_W - 1);
  localparam logic [7:0] YLimit  = 8'(SCR_H - 1);
  localparam logic [3:0] CxLast  = 4'(CUR_W - 1);
  localparam logic [3:0] CyLast  = 4'(CUR_H - 1);

  typedef enum logic [2:0] {StIdle, StErase, StFlush, StDraw, StFinish} state_e;

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;

  // One-cycle delayed copy of the erase request and scanner coordinates, lining the
  // plot up with the background RAM read that the scanner coordinates address.
  logic       del_q;
  logic [7:0] sx_q;
  logic [6:0] sy_q;

  // Cursor pixel position at full width so edge clipping sees the carry.
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign sum_x = {1'b0, px_q} + {5'b0, cx_q};
  assign sum_y = {1'b0, py_q} + {4'b0, cy_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      del_q     <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      px_q      <= px_d;
      py_q      <= py_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      del_q     <= delete_signal;
      sx_q      <= scan_x;
      sy_q      <= scan_y;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    px_d          = px_q;
    py_d          = py_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    delete_signal = 1'b0;
    plot          = 1'b0;
    draw_x        = '0;
    draw_y        = '0;
    colour_sel    = 1'b0;
    done          = 1'b0;
    busy          = (state_q != StIdle);

    // Moves arriving mid-redraw collapse into a single follow-up redraw.
    if (state_q != StIdle && move) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (move || pending_q) begin
          px_d      = mouse_x;
          py_d      = mouse_y;
          pending_d = 1'b0;
          state_d   = StErase;
        end
      end
      StErase: begin
        delete_signal = 1'b1;
        plot          = del_q;
        draw_x        = sx_q;
        draw_y        = sy_q;
        if (scan_x == XLast && scan_y == YLast) state_d = StFlush;
      end
      StFlush: begin
        // Last delayed erase pixel drains here.
        plot    = del_q;
        draw_x  = sx_q;
        draw_y  = sy_q;
        cx_d    = '0;
        cy_d    = '0;
        state_d = StDraw;
      end
      StDraw: begin
        colour_sel = 1'b1;
        draw_x     = sum_x[7:0];
        draw_y     = sum_y[6:0];
        // Off-screen pixels still take their cycle so draw length is fixed.
        plot       = (sum_x <= XLimit) && (sum_y <= YLimit);
        if (cx_q == CxLast) begin
          cx_d = '0;
          if (cy_q == CyLast) begin
            state_d = StFinish;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mouse_redraw_ctrl.sv
module tb_mouse_redraw_ctrl;

  localparam int SW       = 160;
  localparam int SH       = 120;
  localparam int CW       = 4;
  localparam int CH       = 4;
  localparam int EraseLen = SW * SH;
  localparam int RunLen   = 1 + EraseLen + 1 + CW * CH;  // move cycle -> done cycle

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       move = 1'b0;
  logic [7:0] mouse_x = '0;
  logic [6:0] mouse_y = '0;
  logic [7:0] scan_x = '0;
  logic [6:0] scan_y = '0;
  logic       delete_signal, plot, colour_sel, busy, done;
  logic [7:0] draw_x;
  logic [6:0] draw_y;

  // Second instance with a 1x1 cursor
  logic       move1 = 1'b0;
  logic [7:0] mx1 = '0;
  logic [6:0] my1 = '0;
  logic [7:0] scan_x1 = '0;
  logic [6:0] scan_y1 = '0;
  logic       delete1, plot1, col1, busy1, done1;
  logic [7:0] dx1;
  logic [6:0] dy1;

  always #5 clk = ~clk;

  mouse_redraw_ctrl #(.SCR_W(SW), .SCR_H(SH), .CUR_W(CW), .CUR_H(CH)) dut (
    .clk(clk), .resetn(resetn), .move(move), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .scan_x(scan_x), .scan_y(scan_y), .delete_signal(delete_signal), .plot(plot),
    .draw_x(draw_x), .draw_y(draw_y), .colour_sel(colour_sel), .busy(busy), .done(done)
  );

  mouse_redraw_ctrl #(.SCR_W(SW), .SCR_H(SH), .CUR_W(1), .CUR_H(1)) dut1 (
    .clk(clk), .resetn(resetn), .move(move1), .mouse_x(mx1), .mouse_y(my1),
    .scan_x(scan_x1), .scan_y(scan_y1), .delete_signal(delete1), .plot(plot1),
    .draw_x(dx1), .draw_y(dy1), .colour_sel(col1), .busy(busy1), .done(done1)
  );

  // Erase scanner models: raster walk while requested, zero otherwise.
  always @(posedge clk) begin
    if (!delete_signal) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (scan_x == 8'(SW - 1)) begin
      scan_x <= '0;
      scan_y <= (scan_y == 7'(SH - 1)) ? 7'd0 : scan_y + 7'd1;
    end else begin
      scan_x <= scan_x + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (!delete1) begin
      scan_x1 <= '0;
      scan_y1 <= '0;
    end else if (scan_x1 == 8'(SW - 1)) begin
      scan_x1 <= '0;
      scan_y1 <= (scan_y1 == 7'(SH - 1)) ? 7'd0 : scan_y1 + 7'd1;
    end else begin
      scan_x1 <= scan_x1 + 8'd1;
    end
  end

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  m_active = 0;
  bit  m_pend = 0;
  int  m_start = 0;
  int  dut_dones = 0;
  bit  dut1_finished = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected plot stream of one redraw accepted at the end of cycle t.
  task automatic push_run(input int t, input int x, input int y);
    for (int k = 0; k < EraseLen; k++) sbq.push_back('{t + 2 + k, k % SW, k / SW, 0});
    for (int j = 0; j < CH; j++) begin
      for (int i = 0; i < CW; i++) begin
        if (x + i <= SW - 1 && y + j <= SH - 1)
          sbq.push_back('{t + 2 + EraseLen + j * CW + i, x + i, y + j, 1});
      end
    end
  endtask

  // Reference model: a redraw occupies a fixed window of RunLen cycles after its move;
  // moves inside a window collapse to one follow-up.
  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        sbq.delete();
        m_active = 0;
        m_pend   = 0;
      end else if (m_active) begin
        if (move) m_pend = 1;
        if (cyc == m_start + RunLen) m_active = 0;
      end else if (move || m_pend) begin
        m_start  = cyc;
        m_active = 1;
        m_pend   = 0;
        push_run(cyc, int'(mouse_x), int'(mouse_y));
      end
      cyc++;
    end
  end

  // Monitor
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("reset_outputs", int'({plot, delete_signal, busy, done, colour_sel}), 0);
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          ev = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_plot: actual no plot, expected (%0d,%0d) col %0d at cycle %0d",
                   ev.x, ev.y, ev.col, ev.cyc);
        end
        chk("busy", int'(busy), int'(m_active));
        chk("delete_signal", int'(delete_signal), int'(m_active && cyc <= m_start + EraseLen));
        chk("done", int'(done), int'(m_active && cyc == m_start + RunLen));
        if (done) dut_dones++;
        if (plot) begin
          if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
            checks++;
            errors++;
            $display("FAIL unexpected_plot at cycle %0d: actual (%0d,%0d) col %0d, none expected",
                     cyc, draw_x, draw_y, colour_sel);
          end else begin
            ev = sbq.pop_front();
            chk("plot_x", int'(draw_x), ev.x);
            chk("plot_y", int'(draw_y), ev.y);
            chk("colour_sel", int'(colour_sel), ev.col);
          end
        end
      end
    end
  end

  task automatic pulse_move(input logic [7:0] x, input logic [6:0] y);
    @(posedge clk);
    #1;
    mouse_x = x;
    mouse_y = y;
    move    = 1'b1;
    @(posedge clk);
    #1;
    move = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (!busy && !m_active && !m_pend) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: busy %0d after 25000 cycles, expected 0", tag, busy);
  endtask

  // 1x1 cursor at (0,0): one draw plot, done 19203 cycles after move.
  initial begin
    int lat = -1;
    int draws = 0;
    int erases = 0;
    repeat (6) @(posedge clk);
    #1;
    move1 = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (k == 1) move1 = 1'b0;
      if (plot1) begin
        if (col1) begin
          draws++;
          chk("small_draw_x", int'(dx1), 0);
          chk("small_draw_y", int'(dy1), 0);
        end else begin
          erases++;
        end
      end
      if (done1) begin
        lat = k;
        break;
      end
    end
    chk("small_done_latency", lat, 1 + EraseLen + 1 + 1);
    chk("small_draw_count", draws, 1);
    chk("small_erase_count", erases, EraseLen);
    dut1_finished = 1;
  end

  initial begin
    int r1, r2, r3;
    bit found;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Run A at (10,20), with three stray moves during erase while the mouse wanders,
    // settling on (158,118) before done: exactly one follow-up run B there.
    pulse_move(8'd10, 7'd20);
    r1 = $urandom_range(10, 18000);
    r2 = $urandom_range(10, 18000);
    r3 = $urandom_range(10, 18000);
    for (int i = 0; i < 19300; i++) begin
      @(posedge clk);
      #1;
      if (i < 19100) begin
        mouse_x = 8'($urandom_range(0, SW - 1));
        mouse_y = 7'($urandom_range(0, SH - 1));
      end else begin
        mouse_x = 8'd158;
        mouse_y = 7'd118;
      end
      move = (i == r1 || i == r2 || i == r3);
    end
    move = 1'b0;
    wait_idle("run_ab");

    // Run C at a random (possibly off-screen) position, reset mid-erase at scan (80,40).
    pulse_move(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
    found = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (scan_x == 8'd80 && scan_y == 7'd40) begin
        found = 1;
        break;
      end
    end
    chk("reached_scan_80_40", int'(found), 1);
    chk("plot_before_reset", int'(plot), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_plot", int'(plot), 0);
    chk("async_reset_delete", int'(delete_signal), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Run D near the bottom-right corner, with clipping.
    pulse_move(8'($urandom_range(150, 200)), 7'($urandom_range(110, 127)));
    wait_idle("run_d");

    for (int i = 0; i < 100 && !dut1_finished; i++) @(posedge clk);
    chk("small_instance_finished", int'(dut1_finished), 1);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("done_pulses", dut_dones, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
